decoder_8b10b_multilane: RTL and testbench

Parametrised multi-lane 8b/10b decoder. Decodes LANES 10-bit symbols per beat, with running disparity chained lane 0 → lane LANES-1 and carried across beats. Reports per-lane K, comma, code-error and disparity-error flags. Uses valid/ready handshaking on both sides and keeps a saturating error counter. Sits between the deserializer/word aligner and the PCS receive logic.

---
 rtl/decoder_8b10b_multilane_pkg.sv | 38 +++
 rtl/decoder_8b10b_sym.sv | 62 ++++++
 rtl/decoder_8b10b_multilane.sv | 78 +++++++
 tb/tb_decoder_8b10b_multilane.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/decoder_8b10b_multilane_pkg.sv
// pkg_8b10b: shared 8b/10b code tables, K-code constants and decoded-symbol type
package pkg_8b10b;
  localparam logic [5:0] D6_RDN [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
  };
  localparam logic [3:0] D4_RDN [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
  };
  localparam logic [5:0] K28_6B_RDN = 6'b001111;
  localparam logic [5:0] K28_6B_RDP = 6'b110000;
  localparam logic [3:0] A7_RDN = 4'b0111;
  localparam logic [3:0] A7_RDP = 4'b1000;
  localparam logic [9:0] K28_5_RDN = 10'h0FA;
  localparam logic [9:0] K28_5_RDP = 10'h305;
  localparam logic [9:0] K28_7_RDP = 10'h307;
  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       comma;
    logic       code_err;
    logic       disp_err;
    logic       rd_out;
  } sym_dec_t;
  function automatic logic [2:0] ones6(input logic [5:0] v);
    ones6 = 3'd0;
    for (int n = 0; n < 6; n++) ones6 = ones6 + {2'b00, v[n]};
  endfunction
  // Unbalanced codes and 111000 flip for RD+; other balanced codes are shared
  function automatic logic [5:0] alt6(input logic [5:0] c);
    alt6 = (ones6(c) == 3'd3 && c != 6'b111000) ? c : ~c;
  endfunction
  function automatic logic [3:0] alt4(input logic [3:0] c);
    alt4 = (ones6({2'b00, c}) == 3'd2 && c != 4'b1100) ? c : ~c;
  endfunction
endpackage

// File: rtl/decoder_8b10b_sym.sv
// decoder_8b10b_sym: combinational decode of one 10-bit symbol against an incoming RD
module decoder_8b10b_sym
  import pkg_8b10b::*;
(
  input  logic [9:0] sym,
  input  logic       rd_in,
  output sym_dec_t   dec
);
  logic [5:0] c6;
  logic [3:0] c4, f4;
  logic [2:0] w6, w4, wf;
  logic [4:0] x6, x;
  logic [2:0] y;
  logic       hit6, k28, rd6, rd4, d6, d4, bad6, bad4, k28_ok;
  logic       kx_set, a7_set, b7_set, misuse, kx7, code_err, disp_err, err;
  assign c6 = sym[9:4];
  assign c4 = sym[3:0];
  assign k28 = c6 == K28_6B_RDN || c6 == K28_6B_RDP;
  assign f4 = (c6 == K28_6B_RDP) ? ~c4 : c4;
  assign w6 = ones6(c6);
  assign w4 = ones6({2'b00, c4});
  assign wf = ones6({2'b00, f4});
  assign rd6 = (w6 > 3'd3 || c6 == 6'b000111) ? 1'b1 : (w6 < 3'd3 || c6 == 6'b111000) ? 1'b0 : rd_in;
  assign rd4 = (w4 > 3'd2 || c4 == 4'b0011) ? 1'b1 : (w4 < 3'd2 || c4 == 4'b1100) ? 1'b0 : rd6;
  assign d6 = (w6 == 3'd4 && rd_in) || (w6 == 3'd2 && !rd_in) || (c6 == 6'b111000 && rd_in) || (c6 == 6'b000111 && !rd_in);
  assign d4 = (w4 == 3'd3 && rd6) || (w4 == 3'd1 && !rd6) || (c4 == 4'b1100 && rd6) || (c4 == 4'b0011 && !rd6);
  assign bad6 = !(hit6 || k28);
  assign bad4 = w4 == 3'd0 || w4 == 3'd4;
  assign k28_ok = (wf == 3'd1 && f4 != 4'b0001) || (wf == 3'd2 && f4 != 4'b1100);
  assign x = k28 ? 5'd28 : x6;
  assign kx_set = hit6 && (x6 == 5'd23 || x6 == 5'd27 || x6 == 5'd29 || x6 == 5'd30);
  assign a7_set = x6 == 5'd17 || x6 == 5'd18 || x6 == 5'd20;
  assign b7_set = x6 == 5'd11 || x6 == 5'd13 || x6 == 5'd14;
  assign kx7 = kx_set && (c4 == A7_RDN || c4 == A7_RDP);
  assign misuse = !k28 && ((c4 == A7_RDN && !a7_set && !kx_set) || (c4 == A7_RDP && !b7_set && !kx_set) ||
                           (c4 == 4'b1110 && a7_set) || (c4 == 4'b0001 && b7_set));
  assign code_err = bad6 || bad4 || misuse || (k28 && !k28_ok);
  assign disp_err = d6 || d4;
  assign err = code_err || disp_err;
  // Table lookups; alternate-7 codes fall through to y=7
  always_comb begin
    hit6 = 1'b0;
    x6 = 5'd0;
    y = 3'd7;
    for (int n = 0; n < 32; n++)
      if (c6 == D6_RDN[n] || c6 == alt6(D6_RDN[n])) begin
        hit6 = 1'b1;
        x6 = n[4:0];
      end
    for (int n = 0; n < 8; n++)
      if (f4 == D4_RDN[n] || f4 == alt4(D4_RDN[n])) y = n[2:0];
  end
  // Assemble the result; errored symbols report zero data and no K
  always_comb begin
    dec.data = err ? 8'h00 : {y, x};
    dec.k = !err && (k28 || kx7);
    dec.comma = !err && k28 && (y == 3'd1 || y == 3'd5 || y == 3'd7);
    dec.code_err = code_err;
    dec.disp_err = disp_err;
    dec.rd_out = rd4;
  end
endmodule

// File: rtl/decoder_8b10b_multilane.sv
// decoder_8b10b_multilane: LANES-wide 8b/10b decoder with chained RD, handshake register and error counter
module decoder_8b10b_multilane
  import pkg_8b10b::*;
#(
  parameter int LANES = 2,
  parameter int ERR_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [10*LANES-1:0]   s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [8*LANES-1:0]    m_data,
  output logic [LANES-1:0]      m_k,
  output logic [LANES-1:0]      m_comma,
  output logic [LANES-1:0]      m_code_err,
  output logic [LANES-1:0]      m_disp_err,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  rd_out,
  input  logic                  err_clr,
  output logic [ERR_CNT_W-1:0]  err_cnt
);
  logic [8*LANES-1:0] nxt_data;
  logic [LANES-1:0]   nxt_k, nxt_comma, nxt_code, nxt_disp, lane_err;
  logic [ERR_CNT_W:0] sum;
  logic               acc, rd_last;
  assign s_ready = !m_valid || m_ready;
  assign acc = s_valid && s_ready;
  assign lane_err = nxt_code | nxt_disp;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sym_dec_t d;
    logic     rd_i, rd_o;
    if (i == 0) begin : g_head
      assign rd_i = rd_out;
    end else begin : g_tail
      assign rd_i = g_lane[i-1].rd_o;
    end
    decoder_8b10b_sym u_sym (.sym(s_data[10*i +: 10]), .rd_in(rd_i), .dec(d));
    assign rd_o = d.rd_out;
    assign nxt_data[8*i +: 8] = d.data;
    assign nxt_k[i] = d.k;
    assign nxt_comma[i] = d.comma;
    assign nxt_code[i] = d.code_err;
    assign nxt_disp[i] = d.disp_err;
  end
  assign rd_last = g_lane[LANES-1].rd_o;
  // Counter plus this beat's errored lanes, one bit of headroom for saturation
  always_comb begin
    sum = {1'b0, err_cnt};
    for (int n = 0; n < LANES; n++) sum = sum + {{ERR_CNT_W{1'b0}}, lane_err[n]};
  end
  // Output register, running disparity and saturating error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_k <= '0;
      m_comma <= '0;
      m_code_err <= '0;
      m_disp_err <= '0;
      rd_out <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (acc) begin
        m_valid <= 1'b1;
        m_data <= nxt_data;
        m_k <= nxt_k;
        m_comma <= nxt_comma;
        m_code_err <= nxt_code;
        m_disp_err <= nxt_disp;
        rd_out <= rd_last;
      end else if (m_ready) m_valid <= 1'b0;
      if (err_clr) err_cnt <= '0;
      else if (acc) err_cnt <= sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_decoder_8b10b_multilane.sv
// tb_decoder_8b10b_multilane: directed self-checking bench for the two-lane decoder
module tb_decoder_8b10b_multilane;
  import pkg_8b10b::*;
  localparam int LANES = 2;
  localparam int ERR_CNT_W = 4;
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [10*LANES-1:0]  s_data = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [8*LANES-1:0]   m_data;
  logic [LANES-1:0]     m_k, m_comma, m_code_err, m_disp_err;
  logic                 m_valid;
  logic                 m_ready = 1'b1;
  logic                 rd_out;
  logic                 err_clr = 1'b0;
  logic [ERR_CNT_W-1:0] err_cnt;
  int checks = 0;
  int errors = 0;
  int exp_cnt;
  decoder_8b10b_multilane #(.LANES(LANES), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_k(m_k), .m_comma(m_comma), .m_code_err(m_code_err),
    .m_disp_err(m_disp_err), .m_valid(m_valid), .m_ready(m_ready), .rd_out(rd_out),
    .err_clr(err_clr), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic beat(input logic [19:0] d);
    s_data = d;
    s_valid = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask
  task automatic chk_beat(input string tag, input logic [15:0] data, input logic [1:0] k, input logic [1:0] comma,
                          input logic [1:0] code, input logic [1:0] disp, input logic rd, input logic [3:0] cnt);
    chk({tag, "_valid"}, m_valid, 1);
    chk({tag, "_data"}, m_data, data);
    chk({tag, "_k"}, m_k, k);
    chk({tag, "_comma"}, m_comma, comma);
    chk({tag, "_code"}, m_code_err, code);
    chk({tag, "_disp"}, m_disp_err, disp);
    chk({tag, "_rd"}, rd_out, rd);
    chk({tag, "_cnt"}, err_cnt, cnt);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_k", m_k, 0);
    chk("rst_comma", m_comma, 0);
    chk("rst_code", m_code_err, 0);
    chk("rst_disp", m_disp_err, 0);
    chk("rst_rd", rd_out, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_ready", s_ready, 1);
    rst = 1'b0;
    beat({10'h2AA, K28_5_RDN});
    chk_beat("k285n", 16'hB5BC, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 4'd0);
    beat({10'h18B, K28_5_RDP});
    chk_beat("d00_rdn", 16'h00BC, 2'b01, 2'b01, 2'b00, 2'b10, 1'b1, 4'd1);
    beat({10'h2AA, 10'h3FF});
    chk_beat("bad6", 16'hB500, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 4'd2);
    beat({10'h057, K28_7_RDP});
    chk_beat("k237", 16'hF7FC, 2'b11, 2'b01, 2'b00, 2'b00, 1'b1, 4'd2);
    beat({10'h2AA, 10'h341});
    chk_beat("a7miss", 16'hB500, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 4'd3);
    @(posedge clk);
    #1;
    chk("drain_valid", m_valid, 0);
    s_data = {10'h2AA, 10'h155};
    s_valid = 1'b1;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_first", m_data, 16'hB54A);
    chk("stall_first_valid", m_valid, 1);
    s_data = {10'h155, 10'h2AA};
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      chk("stall_ready", s_ready, 0);
      chk("stall_hold", m_data, 16'hB54A);
      chk("stall_rd", rd_out, 0);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_data", m_data, 16'h4AB5);
    chk("release_valid", m_valid, 1);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("release_empty", m_valid, 0);
    exp_cnt = 3;
    for (int n = 0; n < 7; n++) begin
      beat({10'h3FF, 10'h3FF});
      exp_cnt = (exp_cnt + 2 > 15) ? 15 : exp_cnt + 2;
      chk("sat_cnt", err_cnt, exp_cnt);
      chk("sat_code", m_code_err, 2'b11);
    end
    err_clr = 1'b1;
    beat({10'h3FF, 10'h3FF});
    err_clr = 1'b0;
    chk("clr_cnt", err_cnt, 0);
    chk("clr_code", m_code_err, 2'b11);
    beat({10'h2AA, 10'h3FF});
    chk("post_clr_cnt", err_cnt, 1);
    s_data = {10'h2AA, 10'h2AA};
    s_valid = 1'b1;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_stall_ready", s_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_valid", m_valid, 0);
    chk("mrst_data", m_data, 0);
    chk("mrst_code", m_code_err, 0);
    chk("mrst_k", m_k, 0);
    chk("mrst_rd", rd_out, 0);
    chk("mrst_cnt", err_cnt, 0);
    rst = 1'b0;
    s_valid = 1'b0;
    beat({10'h2AA, K28_5_RDN});
    chk_beat("after_rst", 16'hB5BC, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 4'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
